// File: rtl/mips_isa_pkg.sv
// Shared ISA definitions for the EX stage.
// - R-type funct codes for the ALU group and the MULT/DIV/HI-LO group.
// - State encoding of the multiply/divide sequencer.
package mips_isa_pkg;

  localparam int NB_FUNCT = 6;

  // ALU group
  localparam logic [NB_FUNCT-1:0] FUNCT_SLL   = 6'b000000;
  localparam logic [NB_FUNCT-1:0] FUNCT_SRL   = 6'b000010;
  localparam logic [NB_FUNCT-1:0] FUNCT_SRA   = 6'b000011;
  localparam logic [NB_FUNCT-1:0] FUNCT_ADD   = 6'b100000;
  localparam logic [NB_FUNCT-1:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [NB_FUNCT-1:0] FUNCT_SUB   = 6'b100010;
  localparam logic [NB_FUNCT-1:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [NB_FUNCT-1:0] FUNCT_AND   = 6'b100100;
  localparam logic [NB_FUNCT-1:0] FUNCT_OR    = 6'b100101;
  localparam logic [NB_FUNCT-1:0] FUNCT_XOR   = 6'b100110;
  localparam logic [NB_FUNCT-1:0] FUNCT_NOR   = 6'b100111;
  localparam logic [NB_FUNCT-1:0] FUNCT_SLT   = 6'b101010;
  localparam logic [NB_FUNCT-1:0] FUNCT_SLTU  = 6'b101011;

  // HI/LO and multiply/divide group
  localparam logic [NB_FUNCT-1:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [NB_FUNCT-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [NB_FUNCT-1:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [NB_FUNCT-1:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [NB_FUNCT-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [NB_FUNCT-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [NB_FUNCT-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [NB_FUNCT-1:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/mips_muldiv_unit_core.sv
// Iterative radix-2 multiply/divide datapath (unsigned magnitudes only).
// Ports:
//   i_load      : load operands, clear accumulator, counter <= NB_DATA
//   i_load_lo   : value for the low half (multiplier, or dividend)
//   i_load_op   : multiplicand, or divisor
//   i_mul_step  : one shift-add step
//   i_div_step  : one restoring-division step
//   o_prod      : product (MUL) / quotient in the low half (DIV)
//   o_rem       : division remainder
//   o_cnt       : remaining iterations
module muldiv_core #(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [NB_DATA-1:0]     i_load_lo,
  input  logic [NB_DATA-1:0]     i_load_op,
  input  logic                   i_mul_step,
  input  logic                   i_div_step,
  output logic [2*NB_DATA-1:0]   o_prod,
  output logic [NB_DATA-1:0]     o_rem,
  output logic [NB_CNT-1:0]      o_cnt
);

  logic [2*NB_DATA-1:0] prod;
  logic [NB_DATA-1:0]   operand;
  logic [NB_DATA-1:0]   rem;
  logic [NB_CNT-1:0]    cnt;

  logic [NB_DATA:0]     add_sum;
  logic [NB_DATA:0]     part_rem;
  logic                 rem_ge;
  logic [NB_DATA-1:0]   rem_diff;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (LSB) is set; the carry becomes the new MSB after the shift.
  assign add_sum  = {1'b0, prod[2*NB_DATA-1:NB_DATA]} + {1'b0, operand};

  // Divide: shift the next dividend bit into the remainder and trial-subtract.
  // The true difference is always below the divisor, so N bits hold it.
  assign part_rem = {rem, prod[NB_DATA-1]};
  assign rem_ge   = part_rem >= {1'b0, operand};
  assign rem_diff = part_rem[NB_DATA-1:0] - operand;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod    <= '0;
      operand <= '0;
      rem     <= '0;
      cnt     <= '0;
    end else if (i_load) begin
      prod    <= {{NB_DATA{1'b0}}, i_load_lo};
      operand <= i_load_op;
      rem     <= '0;
      cnt     <= NB_CNT'(NB_DATA);
    end else if (i_mul_step) begin
      prod <= prod[0] ? {add_sum, prod[NB_DATA-1:1]}
                      : {1'b0, prod[2*NB_DATA-1:1]};
      cnt  <= cnt - 1'b1;
    end else if (i_div_step) begin
      prod[NB_DATA-1:0] <= {prod[NB_DATA-2:0], rem_ge};
      rem               <= rem_ge ? rem_diff : part_rem[NB_DATA-1:0];
      cnt               <= cnt - 1'b1;
    end
  end

  assign o_prod = prod;
  assign o_rem  = rem;
  assign o_cnt  = cnt;

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS multiply/divide unit with architectural HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle plus a final
// sign-correction cycle) and MTHI/MTLO in the accept cycle.
// Ports:
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_start, i_op        : request strobe and funct code
//   i_flush              : abort any in-flight operation
//   i_data_A, i_data_B   : rs / rt operands, sampled only at accept
//   o_busy               : operation in flight
//   o_done, o_div_zero   : completion pulse, divide-by-zero pulse
//   o_hi, o_lo           : HI / LO registers
module mips_muldiv_unit
  import mips_isa_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = $clog2(NB_DATA) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_flush,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_A,
  input  logic [NB_DATA-1:0] i_data_B,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_zero,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  md_state_t state, next_state;

  logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic is_mul_op, is_div_op, a_neg, b_neg, b_zero, idle_req;
  logic [NB_DATA-1:0] a_mag, b_mag;

  logic load, mul_step, div_step, fix_write;
  logic [NB_DATA-1:0] load_lo, load_op;

  logic [2*NB_DATA-1:0] prod, prod_fix;
  logic [NB_DATA-1:0]   rem;
  logic [NB_CNT-1:0]    cnt;
  logic [NB_DATA-1:0]   fix_hi, fix_lo;

  // Flags captured at accept, consumed in FIX.
  logic is_div_q, neg_res_q, neg_rem_q, dz_q;

  assign op_mult  = i_op == NB_OP'(FUNCT_MULT);
  assign op_multu = i_op == NB_OP'(FUNCT_MULTU);
  assign op_div   = i_op == NB_OP'(FUNCT_DIV);
  assign op_divu  = i_op == NB_OP'(FUNCT_DIVU);
  assign op_mthi  = i_op == NB_OP'(FUNCT_MTHI);
  assign op_mtlo  = i_op == NB_OP'(FUNCT_MTLO);

  assign is_mul_op = op_mult | op_multu;
  assign is_div_op = op_div | op_divu;
  assign a_neg     = (op_mult | op_div) & i_data_A[NB_DATA-1];
  assign b_neg     = (op_mult | op_div) & i_data_B[NB_DATA-1];
  assign a_mag     = a_neg ? -i_data_A : i_data_A;
  assign b_mag     = b_neg ? -i_data_B : i_data_B;
  assign b_zero    = i_data_B == '0;
  assign idle_req  = (state == IDLE) && i_start && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_lo    = '0;
    load_op    = '0;
    mul_step   = 1'b0;
    div_step   = 1'b0;
    fix_write  = 1'b0;
    case (state)
      IDLE: begin
        if (idle_req && is_mul_op) begin
          load       = 1'b1;
          load_lo    = b_mag;
          load_op    = a_mag;
          next_state = MUL;
        end else if (idle_req && is_div_op) begin
          // Divide by zero skips iteration; the raw dividend rides in the
          // low half so FIX can return it as HI.
          load       = 1'b1;
          load_lo    = b_zero ? i_data_A : a_mag;
          load_op    = b_mag;
          next_state = b_zero ? FIX : DIV;
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (cnt == NB_CNT'(1)) next_state = FIX;
      end
      DIV: begin
        div_step = 1'b1;
        if (cnt == NB_CNT'(1)) next_state = FIX;
      end
      FIX: begin
        fix_write  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (i_flush) begin
      next_state = IDLE;
      fix_write  = 1'b0;
    end
  end

  muldiv_core #(
    .NB_DATA (NB_DATA),
    .NB_CNT  (NB_CNT)
  ) u_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (load),
    .i_load_lo  (load_lo),
    .i_load_op  (load_op),
    .i_mul_step (mul_step),
    .i_div_step (div_step),
    .o_prod     (prod),
    .o_rem      (rem),
    .o_cnt      (cnt)
  );

  // Sign correction: quotient/product negated when operand signs differ,
  // remainder follows the dividend sign.
  assign prod_fix = neg_res_q ? -prod : prod;

  always_comb begin
    fix_hi = prod_fix[2*NB_DATA-1:NB_DATA];
    fix_lo = prod_fix[NB_DATA-1:0];
    if (dz_q) begin
      fix_hi = prod[NB_DATA-1:0];
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = neg_rem_q ? -rem : rem;
      fix_lo = neg_res_q ? -prod[NB_DATA-1:0] : prod[NB_DATA-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hi       <= '0;
      o_lo       <= '0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      if (load) begin
        is_div_q  <= is_div_op;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= is_div_op & b_zero;
      end
      if (idle_req && op_mthi) o_hi <= i_data_A;
      if (idle_req && op_mtlo) o_lo <= i_data_A;
      if (fix_write) begin
        o_hi       <= fix_hi;
        o_lo       <= fix_lo;
        o_done     <= 1'b1;
        o_div_zero <= dz_q;
      end
    end
  end

  assign o_busy = state != IDLE;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written flush / reset / timing sequences.
module tb_mips_muldiv_unit;
  import mips_isa_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [5:0]   op = '0;
  logic [N-1:0] a = '0, b = '0;
  logic         busy, done, div_zero;
  logic [N-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mips_muldiv_unit dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_flush    (flush),
    .i_op       (op),
    .i_data_A   (a),
    .i_data_B   (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (div_zero),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model from the ISA definition: returns {div_zero, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [5:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = longint'(x);
    longint unsigned uy = longint'(y);
    logic [63:0]     r, q, m;
    r = '0;
    if (f == FUNCT_MULT) begin
      r = sx * sy;
      return {1'b0, r};
    end else if (f == FUNCT_MULTU) begin
      r = ux * uy;
      return {1'b0, r};
    end else if (y == '0) begin
      return {1'b1, x, {N{1'b1}}};
    end else if (f == FUNCT_DIV) begin
      q = sx / sy;
      m = sx % sy;
      return {1'b0, m[N-1:0], q[N-1:0]};
    end else begin
      q = ux / uy;
      m = ux % uy;
      return {1'b0, m[N-1:0], q[N-1:0]};
    end
  endfunction

  // Issue one operation; called with the bench #1 after a rising edge.
  // Returns the observed results, latency (edges from accept to done) and
  // number of cycles busy was seen high.
  task automatic run_op(input logic [5:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                        output logic [64:0] res, output int lat, output int busy_cyc, output bit got);
    op = f; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;      // operands must not be re-read
    busy_cyc = busy ? 1 : 0;
    lat = 0; got = 1'b0; res = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cyc++;
      if (done) begin
        got = 1'b1;
        res = {div_zero, hi, lo};
      end
    end
  endtask

  typedef struct {
    logic [5:0]   f;
    logic [N-1:0] x, y, exp_hi, exp_lo;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [64:0]  res, exp;
    int           lat, busy_cyc, done_seen;
    bit           got;
    logic [N-1:0] hi0, lo0;
    logic [5:0]   fr;

    vecs[0] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[1] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[2] = '{FUNCT_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[3] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[4] = '{FUNCT_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33};
    vecs[5] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[6] = '{FUNCT_DIVU,  32'd10,       32'd0,        32'd10,       32'hFFFFFFFF, 1'b1, 1};
    vecs[7] = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};

    // Reset state
    #2;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, issued back-to-back in the done cycle
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].f, vecs[i].x, vecs[i].y, res, lat, busy_cyc, got);
      check($sformatf("vec%0d_done", i), 64'(got), 64'h1);
      check($sformatf("vec%0d_hilo", i), res[63:0], {vecs[i].exp_hi, vecs[i].exp_lo});
      check($sformatf("vec%0d_dz", i), 64'(res[64]), 64'(vecs[i].exp_dz));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      if (i == 0) check("mult_busy_cycles", 64'(busy_cyc), 64'd33);
      if (i == 6) check("dz_busy_cycles", 64'(busy_cyc), 64'd1);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] rx, ry;
      case ($urandom_range(0, 3))
        0: fr = FUNCT_MULT;
        1: fr = FUNCT_MULTU;
        2: fr = FUNCT_DIV;
        default: fr = FUNCT_DIVU;
      endcase
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: ry = $urandom_range(1, 15);
        2: ry = -$urandom_range(1, 15);
        default: ry = $urandom;
      endcase
      exp = ref_op(fr, rx, ry);
      run_op(fr, rx, ry, res, lat, busy_cyc, got);
      check($sformatf("rand%0d_done op=%b a=%h b=%h", i, fr, rx, ry), 64'(got), 64'h1);
      check($sformatf("rand%0d_hilo op=%b a=%h b=%h", i, fr, rx, ry), res[63:0], exp[63:0]);
      check($sformatf("rand%0d_dz", i), 64'(res[64]), 64'(exp[64]));
      check($sformatf("rand%0d_lat", i), 64'(lat), exp[64] ? 64'd1 : 64'd33);
    end

    // MTHI / MTLO: immediate write, no busy, no done
    op = FUNCT_MTHI; a = 32'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_value", 64'(hi), 64'h1234);
    check("mthi_flags", {62'h0, busy, done}, 64'h0);
    op = FUNCT_MTLO; a = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_value", 64'(lo), 64'h5678);
    check("mtlo_keeps_hi", 64'(hi), 64'h1234);

    // Flush mid-MULT with an ignored retry while busy
    hi0 = hi; lo0 = lo;
    op = FUNCT_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 5) begin op = FUNCT_DIVU; a = 32'd100; b = 32'd3; start = 1'b1; end
      if (i == 9) flush = 1'b1;
      @(posedge clk); #1;
      if (done) done_seen++;
      if (i == 5) start = 1'b0;
      if (i == 9) begin
        flush = 1'b0;
        check("flush_busy_drop", 64'(busy), 64'h0);
      end
    end
    check("flush_no_done", 64'(done_seen), 64'h0);
    check("flush_hilo_kept", {hi, lo}, {hi0, lo0});

    // Flush together with start drops the start
    op = FUNCT_MULTU; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_with_start", 64'(busy), 64'h0);

    // Flush in the FIX cycle wins: no write
    op = FUNCT_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("fix_cycle_busy", 64'(busy), 64'h1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    done_seen = done ? 1 : 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("fix_flush_no_done", 64'(done_seen), 64'h0);
    check("fix_flush_hilo_kept", {hi, lo}, {hi0, lo0});

    // Asynchronous reset mid-DIV
    op = FUNCT_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'h0);
    check("async_rst_flags", {61'h0, busy, done, div_zero}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(FUNCT_MULT, 32'd6, 32'd7, res, lat, busy_cyc, got);
    check("post_rst_done", 64'(got), 64'h1);
    check("post_rst_mult", res[63:0], {32'd0, 32'd42});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
